relprime_control: RTL and testbench
===================================

RELPRIME_CONTROL -- requirements
Module: relprime_control

Interface
REQ-001 Parameter: MEM_WAIT_MAX, 15, max cycles a memory state waits for MemReady before timeout (1..255).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Reset_n  input  1  reset, synchronous, active-low.
REQ-004 Opcode  input  4  instruction opcode from IR, stable from DECODE on.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MemReady  input  1  memory completion strobe.
REQ-007 ALUSrcASel, ALUSrcBSel, PCSrcSel, MemtoRegSel, RegDstSel  output  3 each  selectors for the 5-input 16-bit datapath muxes.
REQ-008 ALUOp  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
REQ-009 PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite  output  1 each  datapath strobes.
REQ-010 Halted, MemTimeout, IllegalOp  output  1 each  status; State  output  4  current state code.

Function
REQ-011 Opcodes SHALL be: 0-4 R-type (ADD,SUB,AND,OR,SLT), 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, A J, B JAL, F HALT; C-E illegal.
REQ-012 Moore FSM; outputs decoded from State only, except PCWrite/IRWrite (qualified by MemReady, Zero); unlisted outputs are 0 in every state.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0 (PC), ALUSrcB=1 (const 2), ADD, PCSrc=0; IRWrite=PCWrite=MemReady; leave to DECODE only when MemReady=1.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=3 (imm<<1), ADD; next by opcode: R->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, J/JAL->JUMP, HALT->HALT, illegal->FETCH with IllegalOp=1 for that cycle.
REQ-015 EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=Opcode[2:0] -> WB_R (RegDst=1, MemtoReg=0, RegWrite) -> FETCH.
REQ-016 EXEC_I: ALUSrcA=1, ALUSrcB=2 (sext imm), ADD -> WB_I (RegDst=0, MemtoReg=0, RegWrite) -> FETCH.
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD -> MEM_RD (LW) or MEM_WR (SW).
REQ-018 MEM_RD: IorD=1, MemRead; on MemReady -> MEM_WB (RegDst=0, MemtoReg=1, RegWrite) -> FETCH. MEM_WR: IorD=1, MemWrite; on MemReady -> FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=1; PCWrite=Zero (BEQ) or !Zero (BNE) -> FETCH.
REQ-020 JUMP: PCSrc=2, PCWrite=1; JAL additionally RegWrite, RegDst=2, MemtoReg=2 -> FETCH.
REQ-021 Latency with MemReady tied 1: R/ADDI/SW 4 cycles, LW 5, BEQ/BNE/J/JAL 3.
REQ-022 Wait counter clears on entering FETCH/MEM_RD/MEM_WR, increments each waiting cycle; reaching MEM_WAIT_MAX without MemReady -> HALT, MemTimeout sticky 1; MemReady on the limit cycle wins.
REQ-023 HALT: all strobes 0, Halted=1, remains until reset.

Reset
REQ-024 Reset_n=0 at a rising edge SHALL force FETCH, clear wait counter, MemTimeout, retire count, from any state including mid-wait.
REQ-025 While Reset_n=0, all write strobes (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be forced 0 combinationally.

Configuration
REQ-026 Macro RELPRIME_RETIRE_COUNT_EN defined: 16-bit output RetireCount increments on every transition into FETCH from a non-reset state, wraps FFFF->0000; undefined: port and counter absent.

Structure
REQ-027 Package relprime_ctrl_pkg SHALL hold state encodings, opcode constants, ALUOp codes and mux select constants.
REQ-028 Timeout counter SHALL be sub-module mem_wait_timer (clear, enable, limit, expired).

Verification
REQ-029 ADD (op 0), MemReady=1 -> states FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 only in cycle 4, RegDstSel=1.
REQ-030 LW, MemReady low 3 cycles in MEM_RD -> stays MEM_RD 4 cycles, then MEM_WB with MemtoRegSel=1.
REQ-031 BEQ with Zero=1 -> PCWrite=1, PCSrcSel=1 in BRANCH; BNE with Zero=1 -> PCWrite=0.
REQ-032 MemReady held 0 in FETCH, MEM_WAIT_MAX=4 -> HALT after 4 cycles, MemTimeout=1, Halted=1; Reset_n=0 one edge -> FETCH, flags 0.
REQ-033 Opcode D -> IllegalOp=1 one cycle, back to FETCH, no strobe asserted; with RELPRIME_RETIRE_COUNT_EN, 3 ADDs -> RetireCount=3.

Source files
------------

// File: rtl/relprime_ctrl_pkg.sv
// Shared encodings for the relprime multicycle controller: state codes,
// opcodes, ALU operations and datapath mux selects.
package relprime_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_J    = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [2:0] SRCA_PC   = 3'd0;
    localparam logic [2:0] SRCA_REG  = 3'd1;
    localparam logic [2:0] SRCB_REG  = 3'd0;
    localparam logic [2:0] SRCB_TWO  = 3'd1;
    localparam logic [2:0] SRCB_SEXT = 3'd2;
    localparam logic [2:0] SRCB_SHL  = 3'd3;
    localparam logic [2:0] PC_ALU    = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] M2R_ALU   = 3'd0;
    localparam logic [2:0] M2R_MEM   = 3'd1;
    localparam logic [2:0] M2R_PC    = 3'd2;
    localparam logic [2:0] RD_RT     = 3'd0;
    localparam logic [2:0] RD_RD     = 3'd1;
    localparam logic [2:0] RD_LINK   = 3'd2;

    // States that stall on MemReady and are guarded by the wait timer.
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/relprime_control_mem_wait_timer.sv
// Memory wait timer: counts stalled cycles, flags the cycle that reaches the limit.
module mem_wait_timer (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (clear)
            count_reg <= '0;
        else if (enable)
            count_reg <= count_reg + 8'd1;
    end

    // Combinational so that a MemReady arriving on the limit cycle still wins.
    assign expired = enable && (count_reg == limit - 8'd1);
endmodule

// File: rtl/relprime_control.sv
// Multicycle Moore controller for the relprime 16-bit datapath.
// Optional RetireCount output is built when RELPRIME_RETIRE_COUNT_EN is defined.
module relprime_control
    import relprime_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [2:0] ALUSrcASel,
    output logic [2:0] ALUSrcBSel,
    output logic [2:0] PCSrcSel,
    output logic [2:0] MemtoRegSel,
    output logic [2:0] RegDstSel,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       Halted,
    output logic       MemTimeout,
    output logic       IllegalOp,
    output logic [3:0] State
`ifdef RELPRIME_RETIRE_COUNT_EN
    ,
    output logic [15:0] RetireCount
`endif
);
    state_t state_reg, state_next;
    logic   mem_timeout_reg;
    logic   wait_expired;
    logic   pc_write, ir_write, mem_write, reg_write;

    mem_wait_timer u_timer (
        .clk     (CLK),
        .clear   (!Reset_n || (state_next != state_reg)),
        .enable  (is_mem_wait(state_reg) && !MemReady),
        .limit   (8'(MEM_WAIT_MAX)),
        .expired (wait_expired)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_reg       <= S_FETCH;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (wait_expired)
                mem_timeout_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_FETCH:    if (MemReady) state_next = S_DECODE;
                        else if (wait_expired) state_next = S_HALT;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_next = S_EXEC_R;
                    OP_ADDI:        state_next = S_EXEC_I;
                    OP_LW, OP_SW:   state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J, OP_JAL:   state_next = S_JUMP;
                    OP_HALT:        state_next = S_HALT;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_EXEC_I:   state_next = S_WB_I;
            S_MEM_ADDR: state_next = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (MemReady) state_next = S_MEM_WB;
                        else if (wait_expired) state_next = S_HALT;
            S_MEM_WR:   if (MemReady) state_next = S_FETCH;
                        else if (wait_expired) state_next = S_HALT;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ALUSrcASel  = SRCA_PC;
        ALUSrcBSel  = SRCB_REG;
        PCSrcSel    = PC_ALU;
        MemtoRegSel = M2R_ALU;
        RegDstSel   = RD_RT;
        ALUOp       = ALU_ADD;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        Halted      = 1'b0;
        IllegalOp   = 1'b0;
        unique case (state_reg)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcBSel = SRCB_TWO;
                ir_write   = MemReady;
                pc_write   = MemReady;
            end
            S_DECODE: begin
                ALUSrcBSel = SRCB_SHL;
                IllegalOp  = (Opcode >= 4'hC) && (Opcode <= 4'hE);
            end
            S_EXEC_R: begin
                ALUSrcASel = SRCA_REG;
                ALUOp      = Opcode[2:0];
            end
            S_WB_R: begin
                RegDstSel = RD_RD;
                reg_write = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ALUSrcASel = SRCA_REG;
                ALUSrcBSel = SRCB_SEXT;
            end
            S_WB_I:   reg_write = 1'b1;
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoRegSel = M2R_MEM;
                reg_write   = 1'b1;
            end
            S_MEM_WR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcASel = SRCA_REG;
                ALUOp      = ALU_SUB;
                PCSrcSel   = PC_BRANCH;
                pc_write   = (Opcode == OP_BNE) ? !Zero : Zero;
            end
            S_JUMP: begin
                PCSrcSel = PC_JUMP;
                pc_write = 1'b1;
                if (Opcode == OP_JAL) begin
                    reg_write   = 1'b1;
                    RegDstSel   = RD_LINK;
                    MemtoRegSel = M2R_PC;
                end
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    // Write strobes must be quiet during reset even before the state settles.
    assign PCWrite    = pc_write  && Reset_n;
    assign IRWrite    = ir_write  && Reset_n;
    assign MemWrite   = mem_write && Reset_n;
    assign RegWrite   = reg_write && Reset_n;
    assign MemTimeout = mem_timeout_reg;
    assign State      = state_reg;

`ifdef RELPRIME_RETIRE_COUNT_EN
    logic [15:0] retire_count_reg;

    always_ff @(posedge CLK) begin
        if (!Reset_n)
            retire_count_reg <= '0;
        else if ((state_reg != S_FETCH) && (state_next == S_FETCH))
            retire_count_reg <= retire_count_reg + 16'd1;
    end

    assign RetireCount = retire_count_reg;
`endif
endmodule

// File: tb/tb_relprime_control.sv
// Self-checking bench for relprime_control: per-instruction step lists drive a
// reference model; directed scenarios first, then randomized opcodes/stalls/resets.
module tb_relprime_control;
    import relprime_ctrl_pkg::*;

    localparam int WAIT_MAX = 4;

    logic       CLK, Reset_n, Zero, MemReady;
    logic [3:0] Opcode;
    logic [2:0] ALUSrcASel, ALUSrcBSel, PCSrcSel, MemtoRegSel, RegDstSel, ALUOp;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic       Halted, MemTimeout, IllegalOp;
    logic [3:0] State;
`ifdef RELPRIME_RETIRE_COUNT_EN
    logic [15:0] RetireCount;
`endif

    relprime_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .ALUSrcASel(ALUSrcASel), .ALUSrcBSel(ALUSrcBSel), .PCSrcSel(PCSrcSel),
        .MemtoRegSel(MemtoRegSel), .RegDstSel(RegDstSel), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .Halted(Halted),
        .MemTimeout(MemTimeout), .IllegalOp(IllegalOp), .State(State)
`ifdef RELPRIME_RETIRE_COUNT_EN
        , .RetireCount(RetireCount)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [2:0] a, b, pc, m2r, rd, op;
        logic pcw, irw, iord, mrd, mwr, rw, hlt, tmo, ill;
    } outs_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: each instruction is the list of states it visits.
    state_t      steps[$];
    logic [4:0]  dir_q[$];
    int          idx, wcnt;
    bit          halted_m, tmo_m, need_new;
    logic [15:0] ret_m;

    function automatic state_t model_state();
        if (need_new) return S_FETCH;
        if (halted_m) return S_HALT;
        return steps[idx];
    endfunction

    task automatic start_instr();
        logic [4:0] d;
        if (dir_q.size() > 0) d = dir_q.pop_front();
        else d = 5'($urandom);
        Opcode = d[3:0];
        Zero   = d[4];
        steps.delete();
        steps.push_back(S_FETCH);
        steps.push_back(S_DECODE);
        case (d[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin steps.push_back(S_EXEC_R); steps.push_back(S_WB_R); end
            4'h5: begin steps.push_back(S_EXEC_I); steps.push_back(S_WB_I); end
            4'h6: begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_RD); steps.push_back(S_MEM_WB); end
            4'h7: begin steps.push_back(S_MEM_ADDR); steps.push_back(S_MEM_WR); end
            4'h8, 4'h9: steps.push_back(S_BRANCH);
            4'hA, 4'hB: steps.push_back(S_JUMP);
            4'hF: steps.push_back(S_HALT);
            default: ;
        endcase
        idx = 0;
        wcnt = 0;
        need_new = 0;
    endtask

    task automatic reset_model();
        halted_m = 0;
        tmo_m    = 0;
        ret_m    = '0;
        wcnt     = 0;
        need_new = 1;
    endtask

    function automatic outs_t expect_outs(state_t s, logic rdy, logic rstn);
        outs_t e = '0;
        e.tmo = tmo_m;
        case (s)
            S_FETCH:    begin e.mrd = 1; e.b = 1; e.irw = rdy; e.pcw = rdy; end
            S_DECODE:   begin e.b = 3; e.ill = (Opcode == 4'hC || Opcode == 4'hD || Opcode == 4'hE); end
            S_EXEC_R:   begin e.a = 1; e.op = Opcode[2:0]; end
            S_WB_R:     begin e.rd = 1; e.rw = 1; end
            S_EXEC_I:   begin e.a = 1; e.b = 2; end
            S_WB_I:     e.rw = 1;
            S_MEM_ADDR: begin e.a = 1; e.b = 2; end
            S_MEM_RD:   begin e.iord = 1; e.mrd = 1; end
            S_MEM_WB:   begin e.m2r = 1; e.rw = 1; end
            S_MEM_WR:   begin e.iord = 1; e.mwr = 1; end
            S_BRANCH:   begin e.a = 1; e.op = 1; e.pc = 1; e.pcw = (Opcode == 4'h8) ? Zero : !Zero; end
            S_JUMP: begin
                e.pc = 2; e.pcw = 1;
                if (Opcode == 4'hB) begin e.rw = 1; e.rd = 2; e.m2r = 2; end
            end
            S_HALT:     e.hlt = 1;
            default: ;
        endcase
        if (!rstn) begin e.pcw = 0; e.irw = 0; e.mwr = 0; e.rw = 0; end
        return e;
    endfunction

    function automatic outs_t observed();
        return '{a: ALUSrcASel, b: ALUSrcBSel, pc: PCSrcSel, m2r: MemtoRegSel,
                 rd: RegDstSel, op: ALUOp, pcw: PCWrite, irw: IRWrite, iord: IorD,
                 mrd: MemRead, mwr: MemWrite, rw: RegWrite, hlt: Halted,
                 tmo: MemTimeout, ill: IllegalOp};
    endfunction

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic cycle(input logic rdy, input logic rstn);
        state_t cur;
        @(negedge CLK);
        if (need_new) start_instr();
        MemReady = rdy;
        Reset_n  = rstn;
        #1;
        cur = model_state();
        check($sformatf("state@%s", cur.name()), 64'(State), 64'(cur));
        check($sformatf("outs@%s op=%h z=%b rdy=%b rst_n=%b", cur.name(), Opcode, Zero, rdy, rstn),
              64'(observed()), 64'(expect_outs(cur, rdy, rstn)));
`ifdef RELPRIME_RETIRE_COUNT_EN
        check("retire", 64'(RetireCount), 64'(ret_m));
`endif
        if (!rstn) begin
            reset_model();
        end else if (cur == S_HALT) begin
            halted_m = 1;
        end else if ((cur == S_FETCH || cur == S_MEM_RD || cur == S_MEM_WR) && !rdy) begin
            wcnt++;
            if (wcnt == WAIT_MAX) begin
                halted_m = 1;
                tmo_m    = 1;
            end
        end else begin
            wcnt = 0;
            idx++;
            if (idx == steps.size()) begin
                ret_m++;
                need_new = 1;
                $display("instr op=%h zero=%b retired=%0d", Opcode, Zero, ret_m);
            end
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        MemReady = 1'b0;
        Opcode   = 4'h0;
        Zero     = 1'b0;
        reset_model();
        // ADD, LW, BEQ z=1, BNE z=1, illegal D, ADD that times out, then 3 ADDs.
        dir_q = '{5'h00, 5'h06, 5'h18, 5'h19, 5'h0D, 5'h00, 5'h00, 5'h00, 5'h00};
        repeat (2) @(posedge CLK);

        repeat (4) cycle(1, 1);
        repeat (3) cycle(1, 1);
        repeat (3) cycle(0, 1);
        repeat (2) cycle(1, 1);
        repeat (6) cycle(1, 1);
        repeat (2) cycle(1, 1);
        repeat (WAIT_MAX) cycle(0, 1);
        cycle(0, 1);
        cycle(1, 0);
        repeat (12) cycle(1, 1);

        for (int n = 0; n < 3000; n++) begin
            if (model_state() == S_HALT && halted_m)
                cycle(1'($urandom), 0);
            else
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 59) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
